// File: rtl/count_bank_pkg.sv
// count_bank_pkg: shared mode and direction encodings for the counter bank
package count_bank_pkg;
    localparam logic [1:0] MODE_FREE    = 2'b00;
    localparam logic [1:0] MODE_ONESHOT = 2'b01;
    localparam logic [1:0] MODE_MODULO  = 2'b10;
    localparam logic       DIR_UP       = 1'b0;
    localparam logic       DIR_DOWN     = 1'b1;
endpackage

// File: rtl/count_bank_chan.sv
// count_bank_chan: one counter channel with free-run, one-shot and modulo modes
// Ports: clk, resetn (sync, active-low), tick (shared prescaler strobe), en, dir,
//        mode, limit, load, load_val in; cnt (counter), tc (terminal pulse), done out.
module count_bank_chan
    import count_bank_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tick,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             done
);
    localparam logic [WIDTH-1:0] ONES = '1;
    logic             down;
    logic             step;
    logic             fin;
    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] nxt;
    // fin marks a wrap (free/modulo) or arrival at terminal (one-shot) for this step
    always_comb begin
        down = dir == DIR_DOWN;
        step = tick & en & ~load;
        inc  = cnt + WIDTH'(1);
        dec  = cnt - WIDTH'(1);
        term = down ? '0 : ONES;
        nxt  = down ? dec : inc;
        fin  = down ? cnt == '0 : cnt == ONES;
        case (mode)
            MODE_ONESHOT: begin
                nxt = (done || cnt == term) ? cnt : (down ? dec : inc);
                fin = !done && nxt == term;
            end
            MODE_MODULO: begin
                fin = down ? cnt == '0 : cnt >= limit;
                nxt = down ? (fin ? limit : dec) : (fin ? '0 : inc);
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt  <= '0;
            tc   <= 1'b0;
            done <= 1'b0;
        end else if (load) begin
            cnt  <= load_val;
            tc   <= 1'b0;
            done <= 1'b0;
        end else begin
            tc   <= step & fin;
            done <= done | (step & fin & (mode == MODE_ONESHOT));
            if (step)
                cnt <= nxt;
        end
    end
endmodule

// File: rtl/count_bank.sv
// count_bank: bank of counter channels sharing one programmable prescaler
// Ports: clk, resetn (sync, active-low), prescale (tick period - 1), en, dir, mode,
//        limit, load, load_val in; tc, done (per channel), taps (channel MSBs), led out.
// Build option COUNT_BANK_GRAY_EN: taps carry the Gray code of the MSBs instead of binary.
module count_bank
    import count_bank_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CHANNELS   = 4,
    parameter int TAP_BITS   = 8,
    parameter int PRESCALE_W = 16,
    parameter int LED_BIT    = 24
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [PRESCALE_W-1:0]        prescale,
    input  logic [CHANNELS-1:0]          en,
    input  logic [CHANNELS-1:0]          dir,
    input  logic [2*CHANNELS-1:0]        mode,
    input  logic [WIDTH-1:0]             limit,
    input  logic [CHANNELS-1:0]          load,
    input  logic [WIDTH-1:0]             load_val,
    output logic [CHANNELS-1:0]          tc,
    output logic [CHANNELS-1:0]          done,
    output logic [CHANNELS*TAP_BITS-1:0] taps,
    output logic                         led
);
    logic [PRESCALE_W-1:0]             pcnt;
    logic                              tick;
    logic [CHANNELS-1:0][WIDTH-1:0]    cnt;
    logic                              unused_cnt;
    // >= so that lowering prescale below the running count restarts the period at once
    assign tick = pcnt >= prescale;
    always_ff @(posedge clk) begin
        pcnt <= (!resetn || tick) ? '0 : pcnt + PRESCALE_W'(1);
    end
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [TAP_BITS-1:0] msb;
        count_bank_chan #(.WIDTH(WIDTH)) u_chan (
            .clk      (clk),
            .resetn   (resetn),
            .tick     (tick),
            .en       (en[i]),
            .dir      (dir[i]),
            .mode     (mode[2*i+1:2*i]),
            .limit    (limit),
            .load     (load[i]),
            .load_val (load_val),
            .cnt      (cnt[i]),
            .tc       (tc[i]),
            .done     (done[i])
        );
        assign msb = cnt[i][WIDTH-1 -: TAP_BITS];
`ifdef COUNT_BANK_GRAY_EN
        assign taps[TAP_BITS*i +: TAP_BITS] = msb ^ (msb >> 1);
`else
        assign taps[TAP_BITS*i +: TAP_BITS] = msb;
`endif
    end
    assign led        = cnt[0][LED_BIT];
    assign unused_cnt = ^cnt;
endmodule

// File: tb/tb_count_bank.sv
// tb_count_bank: randomized scoreboard bench for count_bank against an arithmetic model
module tb_count_bank;
    localparam int W  = 8;
    localparam int CH = 4;
    localparam int TB = 8;
    localparam int PW = 4;
    localparam int LB = 5;
    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [PW-1:0]    prescale = '0;
    logic [CH-1:0]    en = '0;
    logic [CH-1:0]    dir = '0;
    logic [2*CH-1:0]  mode = '0;
    logic [W-1:0]     limit = '0;
    logic [CH-1:0]    load = '0;
    logic [W-1:0]     load_val = '0;
    logic [CH-1:0]    tc;
    logic [CH-1:0]    done;
    logic [CH*TB-1:0] taps;
    logic             led;
    always #5 clk = ~clk;
    count_bank #(.WIDTH(W), .CHANNELS(CH), .TAP_BITS(TB), .PRESCALE_W(PW), .LED_BIT(LB)) dut (
        .clk(clk), .resetn(resetn), .prescale(prescale), .en(en), .dir(dir), .mode(mode),
        .limit(limit), .load(load), .load_val(load_val), .tc(tc), .done(done), .taps(taps), .led(led)
    );
    typedef struct packed {
        logic [CH-1:0]    tc;
        logic [CH-1:0]    done;
        logic [CH*TB-1:0] taps;
        logic             led;
    } exp_t;
    exp_t q[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;
    int   pc = 0;
    int   c[CH];
    bit   d[CH];
    function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
        end
    endfunction
    // Reference: apply the counter rules to integer state for the upcoming edge
    task automatic cyc();
        exp_t e;
        bit   tk;
        int   t, term, m;
        e = '0;
        if (!resetn) begin
            pc = 0;
            foreach (c[i]) begin
                c[i] = 0;
                d[i] = 0;
            end
        end else begin
            tk = pc >= int'(prescale);
            pc = tk ? 0 : pc + 1;
            for (int i = 0; i < CH; i++) begin
                if (load[i]) begin
                    c[i] = int'(load_val);
                    d[i] = 0;
                end else if (tk && en[i]) begin
                    t = dir[i] ? -1 : 1;
                    m = int'(mode[2*i +: 2]);
                    if (m == 1) begin
                        if (!d[i]) begin
                            term = dir[i] ? 0 : 255;
                            if (c[i] != term) c[i] += t;
                            if (c[i] == term) begin
                                d[i] = 1;
                                e.tc[i] = 1'b1;
                            end
                        end
                    end else if (m == 2) begin
                        if (!dir[i]) begin
                            if (c[i] >= int'(limit)) begin
                                c[i] = 0;
                                e.tc[i] = 1'b1;
                            end else c[i]++;
                        end else if (c[i] == 0) begin
                            c[i] = int'(limit);
                            e.tc[i] = 1'b1;
                        end else c[i]--;
                    end else begin
                        c[i] = (c[i] + t + 256) % 256;
                        e.tc[i] = c[i] == (dir[i] ? 255 : 0);
                    end
                end
            end
        end
        for (int i = 0; i < CH; i++) begin
            e.done[i] = d[i];
`ifdef COUNT_BANK_GRAY_EN
            e.taps[i*TB +: TB] = TB'(c[i] ^ (c[i] >> 1));
`else
            e.taps[i*TB +: TB] = TB'(c[i]);
`endif
        end
        e.led = 1'((c[0] >> LB) & 1);
        q.push_back(e);
        @(negedge clk);
    endtask
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("tc", 64'(tc), 64'(me.tc));
            chk("done", 64'(done), 64'(me.done));
            chk("taps", 64'(taps), 64'(me.taps));
            chk("led", 64'(led), 64'(me.led));
        end
    end
    initial begin
        @(negedge clk);
        resetn = 1'b0;
        cyc();
        cyc();
        resetn = 1'b1;
        en = '1;
        repeat (260) cyc();
        prescale = 4'd3;
        repeat (14) cyc();
        prescale = 4'd1;
        repeat (10) cyc();
        prescale = 4'd0;
        mode[5:4] = 2'b01;
        dir[2] = 1'b1;
        load_val = 8'd5;
        load = 4'b0100;
        cyc();
        load = '0;
        repeat (10) cyc();
        load_val = 8'd3;
        load = 4'b0100;
        cyc();
        load = '0;
        repeat (5) cyc();
        mode[7:6] = 2'b10;
        limit = 8'd9;
        load_val = 8'd0;
        load = 4'b1000;
        cyc();
        load = '0;
        repeat (25) cyc();
        dir[3] = 1'b1;
        load_val = 8'd2;
        load = 4'b1000;
        cyc();
        load = '0;
        repeat (6) cyc();
        limit = 8'd0;
        repeat (4) cyc();
        load_val = 8'h40;
        load = 4'b0010;
        cyc();
        load = '0;
        repeat (3) cyc();
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        repeat (3) cyc();
        mode = '0;
        dir = '0;
        load_val = 8'h7f;
        load = '1;
        cyc();
        load = '0;
        repeat (3) cyc();
        for (int k = 0; k < 3000; k++) begin
            resetn = $urandom_range(0, 299) != 0;
            if ($urandom_range(0, 15) == 0) begin
                prescale = PW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 2));
                mode = 8'($urandom);
                dir = 4'($urandom);
                limit = 8'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 12));
            end
            en = 4'($urandom | $urandom);
            for (int i = 0; i < CH; i++) load[i] = $urandom_range(0, 19) == 0;
            case ($urandom_range(0, 3))
                0: load_val = 8'hff;
                1: load_val = 8'h00;
                default: load_val = 8'($urandom);
            endcase
            cyc();
        end
        load = '0;
        @(posedge clk);
        #2;
        chk("drain", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/count_bank.md
Name: count_bank

Overview:
- Parametrised successor to the free-running board counter.
- N independent counter channels share one programmable prescaler.
- Each channel has enable, up/down direction, load, a per-channel mode (free-run, one-shot, modulo) and a terminal-count pulse.
- Top bits of each channel drive PMOD tap outputs; the LED is driven from channel 0. Sits directly behind the PLL output clock in board top-levels.

Parameters:
- WIDTH, 32: counter width per channel (>=2).
- CHANNELS, 4: number of counter channels (>=1).
- TAP_BITS, 8: MSBs of each counter exported on taps (1..WIDTH).
- PRESCALE_W, 16: prescaler width.
- LED_BIT, 24: bit of channel 0 counter driven onto led (<WIDTH).

Ports:
- clk  in  1  PLL-derived system clock; all logic on posedge.
- resetn  in  1  synchronous active-low reset.
- prescale  in  PRESCALE_W  tick period minus one (0 = tick every cycle).
- en  in  CHANNELS  per-channel count enable.
- dir  in  CHANNELS  per-channel direction, 0 = up, 1 = down.
- mode  in  2*CHANNELS  per-channel mode, channel i at [2i+1:2i].
- limit  in  WIDTH  shared modulo limit for MODULO mode.
- load  in  CHANNELS  per-channel load strobe.
- load_val  in  WIDTH  shared load value.
- tc  out  CHANNELS  one-cycle terminal-count pulse per channel.
- done  out  CHANNELS  one-shot finished flag per channel.
- taps  out  CHANNELS*TAP_BITS  channel i MSBs at [TAP_BITS*(i+1)-1:TAP_BITS*i].
- led  out  1  channel 0 counter bit LED_BIT.

Behaviour:
- Reset (resetn=0 at posedge):
  - prescaler count=0, all counters=0, tc=0, done=0.
  - taps and led therefore read 0 the cycle after reset.
- Prescaler:
  - pcnt counts 0..prescale and then returns to 0.
  - tick=1 on the cycle where pcnt==prescale.
  - prescale=0 gives tick every cycle.
  - If prescale changes to a value below pcnt, pcnt wraps to 0 on the next cycle (treat pcnt>=prescale as terminal).
- Channel step occurs when tick & en[i] & !load[i]. The new value is visible the cycle after the tick (1-cycle latency).
- Modes (2'b11 reserved, behaves as FREE):
  - FREE 2'b00: wraps modulo 2^WIDTH. Up: all-ones->0. Down: 0->all-ones.
  - ONESHOT 2'b01:
    - Up stops at all-ones; down stops at 0.
    - On reaching terminal, done[i] is set and the counter holds.
    - Further ticks are ignored until load.
  - MODULO 2'b10:
    - Up: 0..limit then 0. Down: limit..0 then limit.
    - If the counter is above limit when counting up, the next step goes to 0. Down from a value above limit counts normally.
    - limit=0 holds the counter at 0 with tc on every step.
- tc[i]:
  - Registered pulse, high for exactly one cycle, in the same cycle the counter shows its wrap/terminal value.
  - FREE/MODULO: asserted on each wrap.
  - ONESHOT: asserted once, on arrival at terminal.
- Load:
  - load[i] makes counter=load_val next cycle, clears done[i], and suppresses tc[i].
  - Load beats a simultaneous tick; that tick is lost for channel i only.
  - Multiple channels may load in the same cycle from the shared load_val.
- Direction or mode changes take effect on the next tick. No state is reset on a mode change; done persists until load or reset.
- Reset mid-operation: all state cleared in one cycle. There is no partial state.

Optional Feature:
- Macro COUNT_BANK_GRAY_EN.
- Defined: taps carry the Gray code of each channel's TAP_BITS MSBs, computed as g[k]=b[k]^b[k+1] with the top bit unchanged. This gives glitch-free single-bit transitions on PMOD pins. led stays binary.
- Undefined: taps carry the plain binary MSBs.
- Latency is identical in both cases: taps are combinational from the counter register.

Decomposition:
- Package count_bank_pkg holds:
  - mode localparams MODE_FREE=2'b00, MODE_ONESHOT=2'b01, MODE_MODULO=2'b10;
  - direction constants DIR_UP=0, DIR_DOWN=1.
- Sub-module count_bank_chan:
  - holds one counter, done and tc register;
  - is instantiated CHANNELS times in a generate loop.
- The prescaler and tap/led mapping stay in the top.

Test Plan:
1. Reset then FREE up, prescale=0, en=1, WIDTH=8: counter 0,1,2.. each cycle; after 255 it reads 0 with tc pulse exactly one cycle; led/taps match MSBs.
2. prescale=3, FREE up: counter increments once every 4 cycles. Change prescale to 1 while pcnt=2: pcnt returns to 0 next cycle, then period 2.
3. ONESHOT down, load_val=5: counts 5,4,3,2,1,0; tc and done assert when 0 is reached; further ticks keep 0 with no tc. Load 3 clears done and counting resumes.
4. MODULO up, limit=9: sequence 0..9,0 with tc on each 0. Down with limit=9 from load 2: 2,1,0,9,8.
5. Load and tick in the same cycle on channel 1 only, load_val=0x40: ch1=0x40 next cycle with no tc; ch0 steps normally. Deassert resetn mid-count: all outputs 0 next cycle.
6. With COUNT_BANK_GRAY_EN, TAP_BITS=4, counter MSBs 0111->1000: taps 0100->1100, a single-bit change. Without the macro: taps 0111->1000.
